// File: rtl/dmi_master_pkg.sv
// Shared encodings for the DMI master: DMI op/resp codes, host status codes, FSM states.
package dmi_master_pkg;

   typedef enum logic [1:0] {
      DMI_OP_NOP   = 2'd0,
      DMI_OP_READ  = 2'd1,
      DMI_OP_WRITE = 2'd2,
      DMI_OP_RSVD  = 2'd3
   } dmi_op_e;

   typedef enum logic [1:0] {
      DMI_RESP_OK     = 2'd0,
      DMI_RESP_RSVD   = 2'd1,
      DMI_RESP_FAILED = 2'd2,
      DMI_RESP_BUSY   = 2'd3
   } dmi_resp_e;

   typedef enum logic [1:0] {
      STATUS_OK       = 2'd0,
      STATUS_TIMEOUT  = 2'd1,
      STATUS_FAILED   = 2'd2,
      STATUS_BUSY_EXH = 2'd3
   } rsp_status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Terminal DMI response to host status; the reserved code 1 is reported as a failure.
   function automatic logic [1:0] resp_to_status(input logic [1:0] resp);
      case (resp)
         DMI_RESP_OK:   resp_to_status = STATUS_OK;
         DMI_RESP_BUSY: resp_to_status = STATUS_BUSY_EXH;
         default:       resp_to_status = STATUS_FAILED;
      endcase
   endfunction

endpackage

// File: rtl/dmi_master_timeout_counter.sv
// Per-attempt response timeout: up-counter cleared on each request handshake,
// saturating at TIMEOUT_CYCLES-1 where expire is raised.
module dmi_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   assign expire = (count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dmi_master.sv
// Host-command to DMI bridge: one outstanding DMI transaction with busy retry,
// per-attempt timeout and silent disposal of responses that arrive after a timeout.
//
//   state  | meaning
//   IDLE   | ready for a host command
//   REQ    | DMI request presented, waiting for dmi_req_ready
//   WAIT   | waiting for the DMI response (timeout running)
//   DONE   | result presented to host, waiting for rsp_ready
module dmi_master
   import dmi_master_pkg::*;
#(
   parameter int ADDR_W         = 7,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 4
) (
   input  logic              io_debug_clk,
   input  logic              io_debug_rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [1:0]        rsp_status,
   output logic              dmi_req_valid,
   input  logic              dmi_req_ready,
   output logic [ADDR_W-1:0] dmi_req_bits_addr,
   output logic [31:0]       dmi_req_bits_data,
   output logic [1:0]        dmi_req_bits_op,
   input  logic              dmi_resp_valid,
   output logic              dmi_resp_ready,
   input  logic [31:0]       dmi_resp_bits_data,
   input  logic [1:0]        dmi_resp_bits_resp
);
   localparam int RW = $clog2(MAX_RETRY + 2);

   state_e          state, state_nxt;
   logic            alive;
   logic            drop_q;
   logic [RW-1:0]   retry_q;
   logic            cmd_hs, req_hs, resp_take, retry_now, expire, tmo;

   assign cmd_ready      = (state == S_IDLE) && alive;
   assign dmi_req_valid  = (state == S_REQ);
   assign dmi_resp_ready = (state == S_WAIT) || drop_q;
   assign rsp_valid      = (state == S_DONE);

   assign cmd_hs    = cmd_valid && cmd_ready;
   assign req_hs    = dmi_req_valid && dmi_req_ready;
   // While a stale response is owed, the next response seen belongs to the abandoned attempt.
   assign resp_take = (state == S_WAIT) && dmi_resp_valid && !drop_q;
   assign retry_now = (dmi_resp_bits_resp == DMI_RESP_BUSY) && (retry_q < RW'(MAX_RETRY));
   assign tmo       = (state == S_WAIT) && !resp_take && expire;

   dmi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk    (io_debug_clk),
      .rst_n  (io_debug_rstn),
      .clear  (req_hs),
      .enable ((state == S_WAIT) && !resp_take),
      .expire (expire)
   );

   always_ff @(posedge io_debug_clk or negedge io_debug_rstn) begin
      if (!io_debug_rstn) begin
         state <= S_IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cmd_hs) state_nxt = (cmd_op == DMI_OP_RSVD) ? S_DONE : S_REQ;
         S_REQ:  if (dmi_req_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            if (resp_take)  state_nxt = retry_now ? S_REQ : S_DONE;
            else if (tmo)   state_nxt = S_DONE;
         end
         S_DONE: if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge io_debug_clk or negedge io_debug_rstn) begin
      if (!io_debug_rstn) begin
         dmi_req_bits_op   <= '0;
         dmi_req_bits_addr <= '0;
         dmi_req_bits_data <= '0;
         retry_q           <= '0;
         rsp_data          <= '0;
         rsp_status        <= '0;
         drop_q            <= 1'b0;
      end else begin
         if (cmd_hs) begin
            dmi_req_bits_op   <= cmd_op;
            dmi_req_bits_addr <= cmd_addr;
            dmi_req_bits_data <= cmd_wdata;
            retry_q           <= '0;
            if (cmd_op == DMI_OP_RSVD) begin
               rsp_data   <= '0;
               rsp_status <= STATUS_FAILED;
            end
         end
         if (resp_take) begin
            if (retry_now) begin
               retry_q <= retry_q + 1'b1;
            end else begin
               rsp_data   <= dmi_resp_bits_data;
               rsp_status <= resp_to_status(dmi_resp_bits_resp);
            end
         end
         if (drop_q && dmi_resp_valid) drop_q <= 1'b0;
         if (tmo) begin
            rsp_data   <= '0;
            rsp_status <= STATUS_TIMEOUT;
            drop_q     <= 1'b1;
         end
      end
   end

endmodule
